xcorr_delay_est: RTL and testbench

- Delay estimator that sits directly upstream of the programmable delay line and drives its tap-select input.
- Cross-correlates a reference stream x against a target stream y over one frame, at every lag 0..L-1.
- Reports the best-aligned lag as sel_out, so the delay line can time-align x to y (beamforming / ANC alignment).
- Frame-based: runs one estimate per start request.

---
 rtl/xcorr_delay_est_pkg.sv | 15 +
 rtl/xcorr_delay_est_if.sv | 21 ++
 rtl/xcorr_mac.sv | 28 ++
 rtl/xcorr_delay_est.sv | 133 +++++++++++++
 tb/tb_xcorr_delay_est.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/xcorr_delay_est_pkg.sv
// Shared types and constants for the cross-correlation delay estimator.
package xcorr_delay_est_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int ACC_W_DEF      = 48;
  localparam int FRAME_LOG2_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/xcorr_delay_est_if.sv
// Sample/result bundle between the estimator and its environment.
interface xcorr_delay_est_if
  import xcorr_delay_est_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = ACC_W_DEF
);
  logic                       start;
  logic                       in_valid;
  logic signed [SAMPLE_W-1:0] x_in;
  logic signed [SAMPLE_W-1:0] y_in;
  logic [N-1:0]               sel_out;
  logic signed [ACC_W-1:0]    peak_out;
  logic                       sel_valid;
  logic                       busy;

  modport master (output start, in_valid, x_in, y_in,
                  input  sel_out, peak_out, sel_valid, busy);
  modport slave  (input  start, in_valid, x_in, y_in,
                  output sel_out, peak_out, sel_valid, busy);
endinterface

// File: rtl/xcorr_mac.sv
// Per-lag multiply-accumulate cell: clears on clr, adds sign-extended x*y on en.
module xcorr_mac
  import xcorr_delay_est_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [SAMPLE_W-1:0] y,
  output logic signed [ACC_W-1:0]    acc
);

  logic signed [2*SAMPLE_W-1:0] prod;
  logic signed [ACC_W-1:0]      prod_ext;

  assign prod     = x * y;
  assign prod_ext = {{(ACC_W-2*SAMPLE_W){prod[2*SAMPLE_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod_ext;
  end

endmodule

// File: rtl/xcorr_delay_est.sv
// Frame-based x/y cross-correlation over L lags; reports the best lag for the delay line.
// Build option XCORR_ABS_PEAK_EN: search on |acc| so an inverted target still aligns.
module xcorr_delay_est
  import xcorr_delay_est_pkg::*;
#(
  parameter int N          = 4,
  parameter int L          = 16,
  parameter int FRAME_LOG2 = FRAME_LOG2_DEF,
  parameter int ACC_W      = ACC_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  xcorr_delay_est_if.slave  bus
);

  // state  | meaning
  // IDLE   | waiting for start, history keeps shifting
  // ACCUM  | one frame of samples accumulated into every lag
  // SEARCH | one lag compared per cycle
  // DONE   | result presented with sel_valid
  state_t state_q, state_d;

  logic signed [SAMPLE_W-1:0] hist_q [1:L-1];
  logic signed [SAMPLE_W-1:0] tap    [L];
  logic signed [ACC_W-1:0]    acc    [L];
  logic [FRAME_LOG2-1:0]      cnt_q;
  logic [N-1:0]               scan_q, best_idx_q, sel_q, nxt_idx;
  logic signed [ACC_W-1:0]    best_val_q, peak_q, cand, nxt_val;
  logic                       acc_clr, acc_en, take;

  function automatic logic signed [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] a);
`ifdef XCORR_ABS_PEAK_EN
    if (a == {1'b1, {(ACC_W-1){1'b0}}}) return {1'b0, {(ACC_W-1){1'b1}}};
    else if (a[ACC_W-1])                return -a;
    else                                return a;
`else
    return a;
`endif
  endfunction

  // h[0] is the live sample so the current input pairs with itself at lag 0
  assign tap[0] = bus.x_in;
  for (genvar k = 1; k < L; k++) begin : g_tap
    assign tap[k] = hist_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < L; k++) hist_q[k] <= '0;
    end else if (bus.in_valid) begin
      hist_q[1] <= bus.x_in;
      for (int k = 2; k < L; k++) hist_q[k] <= hist_q[k-1];
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lag
    xcorr_mac #(.ACC_W(ACC_W)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .en    (acc_en),
      .x     (tap[k]),
      .y     (bus.y_in),
      .acc   (acc[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_clr = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_en = 1'b1;
          if (cnt_q == {FRAME_LOG2{1'b1}}) state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: if (scan_q == N'(L-1)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (acc_clr) cnt_q <= '0;
    else if (acc_en)  cnt_q <= cnt_q + 1'b1;
  end

  // Strict compare keeps the lowest lag on ties; lag 0 seeds the running best
  assign cand    = mag(acc[scan_q]);
  assign take    = (scan_q == '0) || (cand > best_val_q);
  assign nxt_val = take ? cand   : best_val_q;
  assign nxt_idx = take ? scan_q : best_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q     <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      sel_q      <= '0;
      peak_q     <= '0;
    end else if (state_q == ST_SEARCH) begin
      scan_q     <= scan_q + 1'b1;
      best_val_q <= nxt_val;
      best_idx_q <= nxt_idx;
      if (scan_q == N'(L-1)) begin
        sel_q  <= nxt_idx;
        peak_q <= nxt_val;
      end
    end else begin
      scan_q <= '0;
    end
  end

  assign bus.sel_out   = sel_q;
  assign bus.peak_out  = peak_q;
  assign bus.sel_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xcorr_delay_est.sv
// Randomised self-checking bench for xcorr_delay_est against a sum-of-products reference.
module tb_xcorr_delay_est;
  import xcorr_delay_est_pkg::*;

  localparam int NB    = 4;
  localparam int LB    = 16;
  localparam int FRM   = 256;
  localparam int TOT   = LB + FRM;
  localparam int ACCWB = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xcorr_delay_est_if #(.N(NB), .ACC_W(ACCWB)) bus ();

  xcorr_delay_est #(.N(NB), .L(LB), .FRAME_LOG2(8), .ACC_W(ACCWB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    sv_cnt  = 0;
  int    x_arr [TOT];
  int    x_save[TOT];

  always @(posedge clk) if (bus.sel_valid === 1'b1) sv_cnt++;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ref_mag(input longint a);
`ifdef XCORR_ABS_PEAK_EN
    return (a < 0) ? -a : a;
`else
    return a;
`endif
  endfunction

  function automatic longint sum_sq(input int lag);
    longint s = 0;
    for (int j = LB; j < TOT; j++) s += longint'(x_arr[j-lag]) * longint'(x_arr[j-lag]);
    return s;
  endfunction

  task automatic gen_random();
    for (int j = 0; j < TOT; j++) x_arr[j] = int'($urandom_range(2000)) - 1000;
  endtask

  task automatic gen_const(input int v);
    for (int j = 0; j < TOT; j++) x_arr[j] = v;
  endtask

  // Prewarm history, start, stream one frame with y = sgn * x delayed by lag,
  // then check the result against sums computed straight from the sample arrays.
  task automatic run_frame(input string tag, input int lag, input int sgn,
                           input int gap, input bit extra_start);
    longint acc_m[LB];
    longint best;
    int     best_k, n, yv;
    for (int k = 0; k < LB; k++) acc_m[k] = 0;
    for (int j = 0; j < LB; j++) begin
      bus.in_valid = 1'b1; bus.x_in = 16'(x_arr[j]); bus.y_in = '0;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val({tag, "_busy_accum"}, 64'(bus.busy), 64'd1);
    for (int j = LB; j < TOT; j++) begin
      for (int g = 1; g < gap; g++) begin
        bus.in_valid = 1'b0;
        tick();
      end
      yv = sgn * x_arr[j-lag];
      bus.in_valid = 1'b1; bus.x_in = 16'(x_arr[j]); bus.y_in = 16'(yv);
      bus.start = extra_start && (j == LB + 100);
      for (int k = 0; k < LB; k++) acc_m[k] += longint'(yv) * longint'(x_arr[j-k]);
      tick();
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    best = ref_mag(acc_m[0]); best_k = 0;
    for (int k = 1; k < LB; k++)
      if (ref_mag(acc_m[k]) > best) begin best = ref_mag(acc_m[k]); best_k = k; end
    n = 1;
    while (bus.sel_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_val({tag, "_latency"}, 64'(n), 64'(LB + 1));
    check_val({tag, "_sel"},     64'(bus.sel_out), 64'(best_k));
    check_val({tag, "_peak"},    bus.peak_out, best);
    check_val({tag, "_busy_at_valid"}, 64'(bus.busy), 64'd1);
    tick();
    check_val({tag, "_pulse_width"}, 64'(bus.sel_valid), 64'd0);
    check_val({tag, "_busy_drop"},   64'(bus.busy), 64'd0);
    for (int j = 0; j < 5; j++) begin
      bus.in_valid = 1'b1; bus.x_in = 16'($urandom); bus.y_in = 16'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    check_val({tag, "_sel_hold"}, 64'(bus.sel_out), 64'(best_k));
  endtask

  initial begin
    int sv_before;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.x_in = '0; bus.y_in = '0;
    #12;
    check_val("rst_sel",   64'(bus.sel_out), 64'd0);
    check_val("rst_peak",  bus.peak_out, 64'sd0);
    check_val("rst_valid", 64'(bus.sel_valid), 64'd0);
    check_val("rst_busy",  64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    tick();

    gen_random();
    x_save = x_arr;
    run_frame("lag5", 5, 1, 1, 1'b0);
    check_val("lag5_spec_sel",  64'(bus.sel_out), 64'd5);
    check_val("lag5_spec_peak", bus.peak_out, sum_sq(5));

    gen_const(100);
    run_frame("tie", 0, 1, 1, 1'b0);
    check_val("tie_spec_sel",  64'(bus.sel_out), 64'd0);
    check_val("tie_spec_peak", bus.peak_out, 64'sd2560000);

    x_arr = x_save;
    run_frame("bursty", 5, 1, 3, 1'b1);
    check_val("bursty_spec_sel",  64'(bus.sel_out), 64'd5);
    check_val("bursty_spec_peak", bus.peak_out, sum_sq(5));

    // Abort mid-frame with reset, then rerun the first frame
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int j = 0; j < 100; j++) begin
      bus.in_valid = 1'b1; bus.x_in = 16'($urandom); bus.y_in = 16'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    sv_before = sv_cnt;
    rst_n = 1'b0;
    #2;
    check_val("midrst_sel",  64'(bus.sel_out), 64'd0);
    check_val("midrst_peak", bus.peak_out, 64'sd0);
    check_val("midrst_busy", 64'(bus.busy), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_val("midrst_no_valid", 64'(sv_cnt), 64'(sv_before));
    check_val("midrst_busy_idle", 64'(bus.busy), 64'd0);
    x_arr = x_save;
    run_frame("rerun", 5, 1, 1, 1'b0);
    check_val("rerun_spec_sel",  64'(bus.sel_out), 64'd5);
    check_val("rerun_spec_peak", bus.peak_out, sum_sq(5));

    gen_const(-32768);
    run_frame("fullscale", 0, 1, 1, 1'b0);
    check_val("fullscale_spec_sel",  64'(bus.sel_out), 64'd0);
    check_val("fullscale_spec_peak", bus.peak_out, 64'sd1 <<< 38);

    gen_random();
    run_frame("invert", 3, -1, 1, 1'b0);
`ifdef XCORR_ABS_PEAK_EN
    check_val("invert_spec_sel",  64'(bus.sel_out), 64'd3);
    check_val("invert_spec_peak", bus.peak_out, sum_sq(3));
`else
    check_val("invert_spec_not3", 64'(bus.sel_out != 4'd3), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
